// File: rtl/key_pkg.sv
// ============================================================================
//  Module      : key_pkg
//  Description : Shared constants and helpers for the key debouncer slice.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package key_pkg;

  // Board defaults: three HaHa KEY buttons, 10 ms filter at 50 MHz
  localparam int KEY_N_BTN           = 3;
  localparam int KEY_DB_CYCLES_50MHZ = 500000;
  localparam int KEY_CODE_W          = 2;

  // Width of an index into n items, never narrower than one bit
  function automatic int clog2_min1(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage : key_pkg

`default_nettype wire

// File: rtl/key_debouncer_if.sv
// ============================================================================
//  Module      : key_debouncer_if
//  Description : Button-side bundle of the debouncer: raw pins in, clean
//                levels, edge pulses and encoded press events out.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface key_debouncer_if #(
  parameter int N_BTN  = key_pkg::KEY_N_BTN,
  parameter int CODE_W = key_pkg::KEY_CODE_W
);

  logic [N_BTN-1:0]  btn_raw;
  logic [N_BTN-1:0]  btn_level;
  logic [N_BTN-1:0]  btn_press;
  logic [N_BTN-1:0]  btn_release;
  logic              evt_valid;
  logic [CODE_W-1:0] evt_code;
  logic              evt_multi;

  // Consumer / stimulus side: drives pins, observes results
  modport master (
    output btn_raw,
    input  btn_level, btn_press, btn_release, evt_valid, evt_code, evt_multi
  );

  // Debouncer side
  modport slave (
    input  btn_raw,
    output btn_level, btn_press, btn_release, evt_valid, evt_code, evt_multi
  );

endinterface : key_debouncer_if

`default_nettype wire

// File: rtl/debounce_channel.sv
// ============================================================================
//  Module      : debounce_channel
//  Description : One button channel: 2-flop synchronizer, polarity
//                normalisation, stability counter, debounced level and
//                registered press/release pulses. i_inhibit_rise blocks a
//                0->1 transition and holds the counter at zero.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module debounce_channel #(
  parameter int STABLE_CYCLES    = 500000,
  parameter int INPUT_ACTIVE_LOW = 1
) (
  input  wire  clk,
  input  wire  rst,             // asynchronous, active low
  input  wire  i_raw,
  input  wire  i_inhibit_rise,
  output logic o_rise_pending,  // a 0->1 flip would happen on the next edge
  output logic o_level,
  output logic o_press,
  output logic o_release
);

  localparam int       CNT_W        = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] C_LIMIT = CNT_W'(STABLE_CYCLES - 1);
  localparam logic     RELEASED_RAW = (INPUT_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  logic             r_sync1;
  logic             r_sync2;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;
  logic             r_press;
  logic             r_release;

  logic w_s;
  logic w_diff;
  logic w_at_limit;
  logic w_hold;
  logic w_toggle;

  // Normalise to active-high after the second flop
  assign w_s        = (INPUT_ACTIVE_LOW != 0) ? ~r_sync2 : r_sync2;
  assign w_diff     = w_s ^ r_level;
  assign w_at_limit = (r_cnt == C_LIMIT);
  // A blocked rise keeps the counter parked at zero
  assign w_hold     = w_diff & ~r_level & i_inhibit_rise;
  assign w_toggle   = w_diff & w_at_limit & ~w_hold;

  // Rise candidacy ignores the inhibit so the top can arbitrate without a loop
  assign o_rise_pending = w_diff & w_at_limit & ~r_level;

  // Two-stage synchronizer, reset to the released pin value
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= RELEASED_RAW;
      r_sync2 <= RELEASED_RAW;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Stability counter: any agreeing cycle restarts it; it never wraps
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (!w_diff || w_hold || w_toggle) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Debounced level and its one-cycle edge pulses, updated together
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_level   <= r_level ^ w_toggle;
      r_press   <= w_toggle & ~r_level;
      r_release <= w_toggle & r_level;
    end
  end

  assign o_level   = r_level;
  assign o_press   = r_press;
  assign o_release = r_release;

endmodule : debounce_channel

`default_nettype wire

// File: rtl/key_debouncer.sv
// ============================================================================
//  Module      : key_debouncer
//  Description : N_BTN debounce channels plus press-event encoding
//                (valid / lowest-index code / multi flag).
//                Optional build macro KEYDB_LOCKOUT_EN: while any level is
//                high no other channel may rise; simultaneous rises resolve
//                to the lowest index and evt_multi is tied low.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_debouncer
  import key_pkg::*;
#(
  parameter int N_BTN            = KEY_N_BTN,
  parameter int STABLE_CYCLES    = KEY_DB_CYCLES_50MHZ,
  parameter int INPUT_ACTIVE_LOW = 1
) (
  input  wire            clk,
  input  wire            rst,   // asynchronous, active low
  key_debouncer_if.slave bus
);

  localparam int CODE_W = clog2_min1(N_BTN);

  logic [N_BTN-1:0]  w_pending;
  logic [N_BTN-1:0]  w_inhibit;
  logic [N_BTN-1:0]  w_rise_go;
  logic [N_BTN-1:0]  w_level;
  logic [N_BTN-1:0]  w_press;
  logic [N_BTN-1:0]  w_release;
  logic [CODE_W-1:0] w_code;
  logic              w_seen;
  logic              w_multi;
  logic              w_multi_en;

  logic              r_evt_valid;
  logic [CODE_W-1:0] r_evt_code;
  logic              r_evt_multi;

  for (genvar gi = 0; gi < N_BTN; gi++) begin : g_ch
    debounce_channel #(
      .STABLE_CYCLES    (STABLE_CYCLES),
      .INPUT_ACTIVE_LOW (INPUT_ACTIVE_LOW)
    ) u_ch (
      .clk            (clk),
      .rst            (rst),
      .i_raw          (bus.btn_raw[gi]),
      .i_inhibit_rise (w_inhibit[gi]),
      .o_rise_pending (w_pending[gi]),
      .o_level        (w_level[gi]),
      .o_press        (w_press[gi]),
      .o_release      (w_release[gi])
    );
  end

`ifdef KEYDB_LOCKOUT_EN
  logic w_lower;

  // Block rises while any button is held, and let only the lowest candidate win
  always_comb begin
    w_inhibit = '0;
    w_lower   = 1'b0;
    for (int i = 0; i < N_BTN; i++) begin
      w_inhibit[i] = (|w_level) | w_lower;
      w_lower      = w_lower | w_pending[i];
    end
  end

  assign w_multi_en = 1'b0;
`else
  assign w_inhibit  = '0;
  assign w_multi_en = 1'b1;
`endif

  // Channels that will show a new 1-level on the next edge
  assign w_rise_go = w_pending & ~w_inhibit;

  // Lowest-index encode and more-than-one detect over next-cycle presses
  always_comb begin
    w_code  = '0;
    w_seen  = 1'b0;
    w_multi = 1'b0;
    for (int i = 0; i < N_BTN; i++) begin
      if (w_rise_go[i]) begin
        if (w_seen) begin
          w_multi = 1'b1;
        end else begin
          w_code = CODE_W'(i);
          w_seen = 1'b1;
        end
      end
    end
  end

  // Event outputs register on the same edge as the press pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_evt_valid <= 1'b0;
      r_evt_code  <= '0;
      r_evt_multi <= 1'b0;
    end else begin
      r_evt_valid <= w_seen;
      r_evt_multi <= w_multi & w_multi_en;
      if (w_seen) begin
        r_evt_code <= w_code;
      end
    end
  end

  assign bus.btn_level   = w_level;
  assign bus.btn_press   = w_press;
  assign bus.btn_release = w_release;
  assign bus.evt_valid   = r_evt_valid;
  assign bus.evt_code    = r_evt_code;
  assign bus.evt_multi   = r_evt_multi;

endmodule : key_debouncer

`default_nettype wire
